// File: rtl/pcma_pkg.sv
// Shared definitions for the PSK mode-detection slice: mode encodings,
// decider FSM state encoding and default widths.
package pcma_pkg;

   localparam int unsigned DIST_WIDTH_DEF   = 16;
   localparam int unsigned LOG2_N_DEF       = 10;
   localparam int unsigned DRAIN_CYCLES_DEF = 32;

   // Same encoding as the upstream fm4_mode / fm8_mode selects
   localparam logic [2:0] MODE_NONE = 3'b000;
   localparam logic [2:0] MODE_QPSK = 3'b001;
   localparam logic [2:0] MODE_8PSK = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACC    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_EVAL   = 3'd3,
      ST_DECIDE = 3'd4
   } dec_state_e;

endpackage

// File: rtl/dist_accumulator.sv
// Accumulates exactly 2^LOG2_N distance samples and exposes their mean.
//   clk, reset_n : clock, synchronous active-low reset
//   clear_i      : zero sum/count/full for a new period
//   valid_i      : sample strobe (ignored once full)
//   data_i       : distance sample
//   full_o       : N samples have been accumulated
//   last_c_o     : combinational, this valid_i completes the N-th sample
//   mean_o       : sum >> LOG2_N (truncating)
module dist_accumulator
   import pcma_pkg::*;
#(
   parameter int unsigned LOG2_N     = LOG2_N_DEF,
   parameter int unsigned DIST_WIDTH = DIST_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear_i,
   input  logic                  valid_i,
   input  logic [DIST_WIDTH-1:0] data_i,
   output logic                  full_o,
   output logic                  last_c_o,
   output logic [DIST_WIDTH-1:0] mean_o
);

   localparam int unsigned SUM_W = DIST_WIDTH + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;
   localparam int unsigned N     = 1 << LOG2_N;

   logic [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             accept;

   assign accept   = valid_i && !full_q;
   assign last_c_o = accept && (cnt_q == CNT_W'(N - 1));

   // Next-state for sum/count; clear wins over a coincident sample
   always_comb begin
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      if (clear_i) begin
         sum_d  = '0;
         cnt_d  = '0;
         full_d = 1'b0;
      end else if (accept) begin
         sum_d  = sum_q + SUM_W'(data_i);
         cnt_d  = cnt_q + CNT_W'(1);
         full_d = last_c_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   // Sum has exactly LOG2_N extra bits, so the shifted mean fits DIST_WIDTH
   assign mean_o = sum_q[SUM_W-1:LOG2_N];
   assign full_o = full_q;

endmodule

// File: rtl/mod_hypothesis_decider.sv
// Runs a QPSK then an 8-PSK accumulation period against the upstream
// distance stage, picks the hypothesis with the smaller mean distance and
// flags lock when that mean is within the latched threshold.
//   clk, reset_n      : clock, synchronous active-low reset
//   start_i, thresh_i : run request and lock threshold (latched on start)
//   dist_val_i/dist_i : distance samples from upstream
//   mode_o, enable_o  : hypothesis mode / period enable to upstream
//   busy_o, done_o    : run in progress / one-cycle result strobe
//   mode_det_o, lock_o, mean_qpsk_o, mean_8psk_o : held decision outputs
module mod_hypothesis_decider
   import pcma_pkg::*;
#(
   parameter int unsigned LOG2_N       = LOG2_N_DEF,
   parameter int unsigned DIST_WIDTH   = DIST_WIDTH_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_i,
   input  logic [DIST_WIDTH-1:0] thresh_i,
   input  logic                  dist_val_i,
   input  logic [DIST_WIDTH-1:0] dist_i,
   output logic [2:0]            mode_o,
   output logic                  enable_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [2:0]            mode_det_o,
   output logic                  lock_o,
   output logic [DIST_WIDTH-1:0] mean_qpsk_o,
   output logic [DIST_WIDTH-1:0] mean_8psk_o
);

   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   dec_state_e state_q, state_d;

   logic [2:0]            mode_q, mode_d;
   logic                  enable_q, enable_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [2:0]            mode_det_q, mode_det_d;
   logic                  lock_q, lock_d;
   logic [DIST_WIDTH-1:0] mean_qpsk_o_q, mean_qpsk_o_d;
   logic [DIST_WIDTH-1:0] mean_8psk_o_q, mean_8psk_o_d;
   logic [DIST_WIDTH-1:0] mean_qpsk_q, mean_qpsk_d;
   logic [DIST_WIDTH-1:0] thresh_q, thresh_d;
   logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;

   logic                  acc_clear, acc_valid, acc_full, acc_last_c;
   logic                  qpsk_wins;
   logic [DIST_WIDTH-1:0] acc_mean;

   dist_accumulator #(
      .LOG2_N     (LOG2_N),
      .DIST_WIDTH (DIST_WIDTH)
   ) u_acc (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (acc_clear),
      .valid_i  (acc_valid),
      .data_i   (dist_i),
      .full_o   (acc_full),
      .last_c_o (acc_last_c),
      .mean_o   (acc_mean)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; the current hypothesis is carried by mode_q
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_ACC;
         ST_ACC:    if (acc_last_c || acc_full) state_d = ST_DRAIN;
         ST_DRAIN:  if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = ST_EVAL;
         ST_EVAL:   state_d = (mode_q == MODE_QPSK) ? ST_ACC : ST_DECIDE;
         ST_DECIDE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values. Outputs are registered from the
   // transition, so decision values are formed in EVAL and become visible
   // together with done_o during DECIDE.
   always_comb begin
      mode_d        = mode_q;
      enable_d      = 1'b0;
      busy_d        = (state_d != ST_IDLE);
      done_d        = 1'b0;
      mode_det_d    = mode_det_q;
      lock_d        = lock_q;
      mean_qpsk_o_d = mean_qpsk_o_q;
      mean_8psk_o_d = mean_8psk_o_q;
      mean_qpsk_d   = mean_qpsk_q;
      thresh_d      = thresh_q;
      drain_cnt_d   = '0;
      acc_clear     = 1'b0;
      acc_valid     = 1'b0;
      qpsk_wins     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            mode_d = MODE_QPSK;
            if (start_i) begin
               thresh_d  = thresh_i;
               acc_clear = 1'b1;
               enable_d  = 1'b1;
            end
         end
         ST_ACC: begin
            acc_valid = dist_val_i;
            enable_d  = !(acc_last_c || acc_full);
         end
         ST_DRAIN: begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
         end
         ST_EVAL: begin
            if (mode_q == MODE_QPSK) begin
               mean_qpsk_d = acc_mean;
               mode_d      = MODE_8PSK;
               acc_clear   = 1'b1;
               enable_d    = 1'b1;
            end else begin
               // Tie goes to QPSK
               qpsk_wins     = (mean_qpsk_q <= acc_mean);
               mode_det_d    = qpsk_wins ? MODE_QPSK : MODE_8PSK;
               lock_d        = (qpsk_wins ? mean_qpsk_q : acc_mean) <= thresh_q;
               mean_qpsk_o_d = mean_qpsk_q;
               mean_8psk_o_d = acc_mean;
               done_d        = 1'b1;
            end
         end
         ST_DECIDE: begin
            mode_d = MODE_QPSK;
         end
         default: begin
            mode_d = MODE_QPSK;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q        <= MODE_QPSK;
         enable_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mode_det_q    <= MODE_NONE;
         lock_q        <= 1'b0;
         mean_qpsk_o_q <= '0;
         mean_8psk_o_q <= '0;
         mean_qpsk_q   <= '0;
         thresh_q      <= '0;
         drain_cnt_q   <= '0;
      end else begin
         mode_q        <= mode_d;
         enable_q      <= enable_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mode_det_q    <= mode_det_d;
         lock_q        <= lock_d;
         mean_qpsk_o_q <= mean_qpsk_o_d;
         mean_8psk_o_q <= mean_8psk_o_d;
         mean_qpsk_q   <= mean_qpsk_d;
         thresh_q      <= thresh_d;
         drain_cnt_q   <= drain_cnt_d;
      end
   end

   assign mode_o      = mode_q;
   assign enable_o    = enable_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign mode_det_o  = mode_det_q;
   assign lock_o      = lock_q;
   assign mean_qpsk_o = mean_qpsk_o_q;
   assign mean_8psk_o = mean_8psk_o_q;

endmodule
